qr_pixel_writer: RTL and testbench
==================================

Name: qr_pixel_writer

Overview:
- Writes a rendered QR module matrix into the 4-bit-wide pixel SRAM. This is the writer side of the image SRAM that the black-pixel search block reads.
- Accepts a 1-bit pixel stream in raster order (row-major, left to right) and packs 4 pixels per SRAM word.
- Applies the same nibble bit-order convention as the reader, selected by mode.
- Places each row at a fixed word stride from a base address and pulses done when the frame is fully written.

Parameters:
- COLS, 21, pixels per row.
- ROWS, 21, rows per frame.
- ROW_STRIDE, 8, SRAM words between row starts. Elaboration check: ceil(COLS/4) <= ROW_STRIDE.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  frame start pulse
- base_addr  input  8  SRAM word address of row 0, word 0; latched on accepted start
- mode  input  1  bit order: 0 = leftmost pixel in bit0; 1 = leftmost pixel in bit3; latched on accepted start
- pix_valid  input  1  pixel stream valid
- pix_data  input  1  pixel value, 1 = black
- pix_ready  output  1  block can accept a pixel this cycle
- sram_wen  output  1  write strobe, one cycle per word
- sram_waddr  output  8  write word address
- sram_wdata  output  4  packed pixel word
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse coincident with the final word write

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: pix_ready=0, sram_wen=0, sram_waddr=0, sram_wdata=0, busy=0, done=0. Internal counters and state are cleared.
- States: IDLE, RUN, FIN.
- IDLE -> RUN on start. In the same edge: latch base_addr and mode, clear col/row/word counters and the pack register.
- RUN: pix_ready=1. A pixel is accepted when pix_valid && pix_ready.
  - An accepted pixel is placed at slot s = col mod 4. Mode 0 writes bit s; mode 1 writes bit 3-s.
  - A word completes on acceptance when s==3 or col==COLS-1. Unfilled bits of a partial last word are 0 (white).
  - Latency: on the cycle after a word completes, sram_wen=1, sram_waddr = base + row*ROW_STRIDE + word_idx, sram_wdata = packed word. All three outputs are registered.
  - Address arithmetic is 8-bit, modulo 256; wrap is silent.
- Counters: col runs 0..COLS-1 and wraps to 0 with row+1. word_idx clears at row end.
- Pixel rate: pixels are accepted back-to-back. A write happens in the same cycle as the next pixel's acceptance; the pack register is cleared on word completion, so no stall is needed.
- RUN -> FIN on acceptance of pixel (ROWS-1, COLS-1). pix_ready drops to 0 in the next cycle.
- FIN: the final write is presented with done=1 in the same cycle; next state is IDLE.
- busy=1 in RUN and FIN.
- start is ignored in RUN and FIN. Pixels offered in IDLE or FIN are not accepted.
- Gaps in pix_valid stall progress without side effects; the partial pack is held.
- rst mid-frame: return to IDLE immediately, no further write, done not asserted. Words already written stay in SRAM.
- Exactly ROWS*ceil(COLS/4) writes per frame. Defaults: 21*6 = 126 writes.

Decomposition:
- Shared package: state enum (IDLE/RUN/FIN), mode constants MODE_LSB_FIRST=0 and MODE_MSB_FIRST=1, SRAM word width 4, SRAM address width 8. The mode constants are reused by the black-pixel search block.
- Sub-module qr_pixel_packer: slot index, mode-dependent bit placement, clear on completion, outputs word and complete flag. The top level holds the FSM, counters and address generation.

Test Plan:
- Defaults, base_addr=0x10, mode=0, all-ones stream every cycle. First write addr=0x10 data=0xF one cycle after the 4th accepted pixel. Row 0 last word addr=0x15 data=0x1. Row 1 first word addr=0x18. Final write addr=0xB5 data=0x1 with done=1. 126 writes total.
- Pixels 1,0,0,0: mode=0 gives data=0x1; mode=1 gives data=0x8. Row tail single black pixel with mode=1 gives data=0x8.
- Random pix_valid gaps (~50%). Write sequence and data identical to the gapless run; no write without a completed word.
- base_addr=0xF0. Row 2 word 0 addr wraps to 0x00. No error flag; done still pulses.
- start re-pulsed mid-frame with base_addr=0x40: ignored, addresses continue from the original base. After done, a new start is accepted.
- rst asserted after 50 pixels: next cycle all outputs at reset values, no further sram_wen, no done. A fresh frame then completes normally.

Source files
------------

// File: rtl/qr_pixel_writer_pkg.sv
// Shared types and constants for the QR pixel SRAM writer/reader pair.
// Mode constants are also used by the black-pixel search block.
package qr_pixel_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic MODE_LSB_FIRST = 1'b0;
  localparam logic MODE_MSB_FIRST = 1'b1;

  localparam int WORD_W = 4;
  localparam int ADDR_W = 8;

  function automatic logic [1:0] slot_bit(
    input logic [1:0] slot,
    input logic       mode
  );
    return (mode == MODE_MSB_FIRST) ? (2'd3 - slot) : slot;
  endfunction

endpackage

// File: rtl/qr_pixel_packer.sv
// Packs accepted pixels into a 4-bit word using the selected nibble order.
// The pack register clears as the word completes.
module qr_pixel_packer
  import qr_pixel_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              accept,
  input  logic              pix,
  input  logic [1:0]        slot,
  input  logic              last_col,
  input  logic              mode,
  output logic [WORD_W-1:0] word,
  output logic              complete
);

  logic [WORD_W-1:0] pack_q;

  // word already includes the pixel being accepted this cycle
  always_comb begin
    word = pack_q;
    if (accept && pix) begin
      word[slot_bit(slot, mode)] = 1'b1;
    end
  end

  assign complete = accept && ((slot == 2'd3) || last_col);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pack_q <= '0;
    end else if (accept) begin
      pack_q <= complete ? '0 : word;
    end
  end

endmodule

// File: rtl/qr_pixel_writer.sv
// Raster pixel stream to 4-bit SRAM words, one row per ROW_STRIDE words.
// Holds the frame FSM, counters and write address generation.
module qr_pixel_writer
  import qr_pixel_writer_pkg::*;
#(
  parameter int COLS       = 21,
  parameter int ROWS       = 21,
  parameter int ROW_STRIDE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mode,
  input  logic              pix_valid,
  input  logic              pix_data,
  output logic              pix_ready,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [WORD_W-1:0] sram_wdata,
  output logic              busy,
  output logic              done
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int NW = (COLS + 3) / 4;

  generate
    if (NW > ROW_STRIDE) begin : g_stride_chk
      $error("ROW_STRIDE too small for COLS");
    end
  endgenerate

  state_t state_q, state_d;

  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [ADDR_W-1:0] word_q;
  logic [ADDR_W-1:0] row_off_q;
  logic [ADDR_W-1:0] base_q;
  logic              mode_q;

  logic              accept;
  logic              launch;
  logic              last_col;
  logic              last_row;
  logic [1:0]        slot;
  logic [WORD_W-1:0] word;
  logic              complete;

  assign pix_ready = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign accept    = pix_valid && pix_ready;
  assign launch    = (state_q == IDLE) && start;
  assign last_col  = (col_q == CW'(COLS - 1));
  assign last_row  = (row_q == RW'(ROWS - 1));
  assign slot      = 2'(32'(col_q) % 4);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && last_col && last_row) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      word_q    <= '0;
      row_off_q <= '0;
      base_q    <= '0;
      mode_q    <= MODE_LSB_FIRST;
    end else begin
      state_q <= state_d;
      if (launch) begin
        base_q    <= base_addr;
        mode_q    <= mode;
        col_q     <= '0;
        row_q     <= '0;
        word_q    <= '0;
        row_off_q <= '0;
      end else if (accept) begin
        if (last_col) begin
          col_q     <= '0;
          word_q    <= '0;
          row_q     <= row_q + RW'(1);
          row_off_q <= row_off_q + ADDR_W'(ROW_STRIDE);
        end else begin
          col_q <= col_q + CW'(1);
          if (slot == 2'd3) word_q <= word_q + ADDR_W'(1);
        end
      end
    end
  end

  qr_pixel_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (launch),
    .accept   (accept),
    .pix      (pix_data),
    .slot     (slot),
    .last_col (last_col),
    .mode     (mode_q),
    .word     (word),
    .complete (complete)
  );

  // address wraps modulo 256 by width
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_wen   <= 1'b0;
      sram_waddr <= '0;
      sram_wdata <= '0;
      done       <= 1'b0;
    end else begin
      sram_wen <= complete;
      done     <= complete && last_col && last_row;
      if (complete) begin
        sram_waddr <= base_q + row_off_q + word_q;
        sram_wdata <= word;
      end
    end
  end

endmodule

// File: tb/tb_qr_pixel_writer.sv
// Directed bench for qr_pixel_writer against a frame-level write model.
// Checks every SRAM write, frame counts, reset and abort behaviour.
module tb_qr_pixel_writer;

  localparam int COLS   = 21;
  localparam int ROWS   = 21;
  localparam int STRIDE = 8;
  localparam int NW     = (COLS + 3) / 4;
  localparam int NPIX   = ROWS * COLS;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic       mode;
  logic       pix_valid;
  logic       pix_data;
  logic       pix_ready;
  logic       sram_wen;
  logic [7:0] sram_waddr;
  logic [3:0] sram_wdata;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] addr;
    logic [3:0] data;
    logic       last;
  } wr_t;

  wr_t expq[$];
  wr_t e;
  bit  pix [NPIX];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nwr   = 0;
  int ndone = 0;
  int nacc  = 0;
  int acc4_cyc     = 0;
  int first_wr_cyc = 0;

  always #5 clk = ~clk;

  qr_pixel_writer #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .ROW_STRIDE (STRIDE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .mode       (mode),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .sram_wen   (sram_wen),
    .sram_waddr (sram_waddr),
    .sram_wdata (sram_wdata),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // expected write list for the whole frame, straight from the layout rules
  task automatic build_exp(input logic [7:0] b, input logic m);
    expq.delete();
    for (int r = 0; r < ROWS; r++) begin
      for (int w = 0; w < NW; w++) begin
        wr_t x;
        x.data = 4'h0;
        for (int s = 0; s < 4; s++) begin
          int c;
          c = w * 4 + s;
          if (c < COLS && pix[r * COLS + c]) x.data[m ? 3 - s : s] = 1'b1;
        end
        x.addr = 8'((int'(b) + r * STRIDE + w) % 256);
        x.last = (r == ROWS - 1) && (w == NW - 1);
        expq.push_back(x);
      end
    end
  endtask

  task automatic fill_ones();
    for (int i = 0; i < NPIX; i++) pix[i] = 1'b1;
  endtask

  task automatic fill_col4();
    for (int i = 0; i < NPIX; i++) pix[i] = ((i % COLS) % 4) == 0;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NPIX; i++) pix[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, {31'd0, pix_ready}, 0);
    chk({tag, "_wen"},   {31'd0, sram_wen},  0);
    chk({tag, "_addr"},  {24'd0, sram_waddr}, 0);
    chk({tag, "_data"},  {28'd0, sram_wdata}, 0);
    chk({tag, "_busy"},  {31'd0, busy}, 0);
    chk({tag, "_done"},  {31'd0, done}, 0);
  endtask

  // single compare process: every write against the model queue
  always @(negedge clk) begin
    cyc++;
    if (sram_wen) begin
      nwr++;
      if (nwr == 1) first_wr_cyc = cyc;
      if (expq.size() == 0) begin
        chk("extra_write", {31'd0, sram_wen}, 0);
      end else begin
        e = expq.pop_front();
        chk("wr_addr", {24'd0, sram_waddr}, {24'd0, e.addr});
        chk("wr_data", {28'd0, sram_wdata}, {28'd0, e.data});
        chk("wr_done", {31'd0, done}, {31'd0, e.last});
      end
    end else if (done) begin
      chk("done_without_wen", {31'd0, done}, 0);
    end
    if (done) ndone++;
    if (pix_valid && pix_ready) begin
      nacc++;
      if (nacc == 4) acc4_cyc = cyc;
    end
  end

  task automatic run_frame(input logic [7:0] b, input logic m,
                           input bit gaps, input int restart_at,
                           input int abort_at);
    int k;
    int guard;
    nwr   = 0;
    ndone = 0;
    nacc  = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = b;
    mode      = m;
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = 8'h00;
    mode      = ~m;
    chk("busy_in_run", {31'd0, busy}, 1);
    k     = 0;
    guard = 0;
    while (k < NPIX && guard < 20000) begin
      pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_data  = pix[k];
      if (k == restart_at) begin
        start     = 1'b1;
        base_addr = 8'h40;
      end
      @(negedge clk);
      if (pix_valid && pix_ready) k++;
      @(posedge clk); #1;
      start = 1'b0;
      guard++;
      if (abort_at > 0 && k == abort_at) break;
    end
    chk("stream_timeout", guard < 20000 ? 0 : 1, 0);
    if (abort_at > 0) begin
      rst       = 1'b1;
      pix_valid = 1'b0;
      @(posedge clk); #1;
      chk_reset_outs("abort");
      expq.delete();
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_writes", nwr, 14);
      chk("abort_no_done", ndone, 0);
      chk("abort_idle_busy", {31'd0, busy}, 0);
    end else begin
      // keep offering pixels through FIN; none may be accepted
      repeat (3) @(negedge clk);
      pix_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("frame_writes", nwr, NW * ROWS);
      chk("frame_dones", ndone, 1);
      chk("frame_exp_left", expq.size(), 0);
      chk("frame_accepted", nacc, NPIX);
      chk("frame_busy_end", {31'd0, busy}, 0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = 8'h00;
    mode      = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk_reset_outs("reset");
    rst = 1'b0;

    // all-ones frame, base 0x10, LSB-first
    fill_ones();
    build_exp(8'h10, 1'b0);
    chk("pin_n", expq.size(), 126);
    chk("pin_first", {expq[0].addr, expq[0].data}, 12'h10F);
    chk("pin_row0_tail", {expq[5].addr, expq[5].data}, 12'h151);
    chk("pin_row1_addr", {24'd0, expq[6].addr}, 32'h18);
    chk("pin_final", {expq[125].addr, expq[125].data, expq[125].last},
        {8'hB5, 4'h1, 1'b1});
    run_frame(8'h10, 1'b0, 1'b0, -1, -1);
    chk("first_write_latency", first_wr_cyc - acc4_cyc, 1);

    // 1,0,0,0 pattern in both nibble orders
    fill_col4();
    build_exp(8'h20, 1'b0);
    chk("pin_m0_word", {28'd0, expq[0].data}, 32'h1);
    chk("pin_m0_tail", {28'd0, expq[5].data}, 32'h1);
    run_frame(8'h20, 1'b0, 1'b0, -1, -1);
    build_exp(8'h20, 1'b1);
    chk("pin_m1_word", {28'd0, expq[0].data}, 32'h8);
    chk("pin_m1_tail", {28'd0, expq[5].data}, 32'h8);
    run_frame(8'h20, 1'b1, 1'b0, -1, -1);

    // ~50% valid gaps: same writes as gapless
    fill_ones();
    build_exp(8'h10, 1'b0);
    run_frame(8'h10, 1'b0, 1'b1, -1, -1);
    fill_rand();
    build_exp(8'h33, 1'b1);
    run_frame(8'h33, 1'b1, 1'b1, -1, -1);

    // address wrap
    fill_rand();
    build_exp(8'hF0, 1'b0);
    chk("pin_wrap", {24'd0, expq[12].addr}, 32'h00);
    run_frame(8'hF0, 1'b0, 1'b0, -1, -1);

    // start re-pulsed mid-frame is ignored
    fill_rand();
    build_exp(8'h10, 1'b1);
    run_frame(8'h10, 1'b1, 1'b0, 30, -1);

    // reset after 50 pixels, then a fresh frame
    fill_ones();
    build_exp(8'h10, 1'b0);
    run_frame(8'h10, 1'b0, 1'b0, -1, 50);
    fill_col4();
    build_exp(8'h80, 1'b1);
    run_frame(8'h80, 1'b1, 1'b0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
